sh7034_itu_irq_arb: RTL and testbench

Interrupt request arbiter for the 16-bit integrated timer unit (ITU). It collects the 15 timer interrupt lines (IMIA/IMIB/OVI for channels 0–4) and applies the per-channel priority levels from the interrupt controller. It presents one registered request (level plus vector) to the CPU interrupt interface and handles the acknowledge handshake. A served source is masked until its line drops, so that a single flag is never taken twice.

---
 rtl/sh7034_pkg.sv | 30 +++
 rtl/sh7034_itu_prio_enc.sv | 29 ++
 rtl/sh7034_itu_irq_arb.sv | 143 ++++++++++++++
 tb/tb_sh7034_itu_irq_arb.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sh7034_pkg.sv
// Shared types and helpers for the SH7034 ITU interrupt request arbiter.
// Source index convention: 3*channel + {0:IMIA, 1:IMIB, 2:OVI}.
package sh7034_pkg;

   localparam int ITU_NCH  = 5;
   localparam int ITU_NSRC = 3 * ITU_NCH;

   typedef logic [ITU_NSRC-1:0] ITU_IRQ_t;

   localparam logic [7:0] ITU_VEC_BASE = 8'd24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } IrqArbState_t;

   // Vector = base + 4*ch + src; the fourth slot of each channel is reserved.
   function automatic logic [7:0] itu_vec(input logic [7:0] base, input logic [3:0] idx);
      logic [7:0] v;
      v = base;
      for (int ch = 0; ch < ITU_NCH; ch++) begin
         for (int s = 0; s < 3; s++) begin
            if (idx == 4'(3 * ch + s)) v = base + 8'(4 * ch + s);
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/sh7034_itu_prio_enc.sv
// Combinational winner selection over the eligible ITU sources.
// Highest level wins; ties go to the first source in index order (low channel, then IMIA/IMIB/OVI).
module sh7034_itu_prio_enc
   import sh7034_pkg::*;
(
   input  ITU_IRQ_t    elig_i,
   input  logic [19:0] ipr_i,
   output logic        valid_o,
   output logic [3:0]  idx_o,
   output logic [3:0]  lvl_o
);

   always_comb begin
      valid_o = 1'b0;
      idx_o   = 4'd0;
      lvl_o   = 4'd0;
      // Strict compare keeps the earlier source on ties and never lets level 0 win.
      for (int ch = 0; ch < ITU_NCH; ch++) begin
         for (int s = 0; s < 3; s++) begin
            if (elig_i[3*ch+s] && (ipr_i[4*ch +: 4] > lvl_o)) begin
               valid_o = 1'b1;
               idx_o   = 4'(3 * ch + s);
               lvl_o   = ipr_i[4*ch +: 4];
            end
         end
      end
   end

endmodule

// File: rtl/sh7034_itu_irq_arb.sv
// ITU interrupt arbiter: presents one registered level/vector to the CPU and masks
// each acknowledged source until its line drops.
module sh7034_itu_irq_arb
   import sh7034_pkg::*;
#(
   parameter logic [7:0] VEC_BASE = ITU_VEC_BASE
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE_R,
   input  logic        RES_N,
   input  logic [4:0]  IMIA_IRQ,
   input  logic [4:0]  IMIB_IRQ,
   input  logic [4:0]  OVI_IRQ,
   input  logic [19:0] IPR,
   output logic        INT_REQ,
   output logic [3:0]  INT_LVL,
   output logic [7:0]  INT_VEC,
   input  logic        INT_ACK,
   output logic [14:0] SERVED,
   output logic [1:0]  ARB_STATE
);

   // Handshake: INT_REQ high means INT_LVL/INT_VEC are valid; an INT_ACK seen on a
   // CE_R edge while INT_REQ is high consumes exactly the values presented in that cycle.

   IrqArbState_t state_q, state_d;
   logic         req_q, req_d;
   logic [3:0]   lvl_q, lvl_d;
   logic [7:0]   vec_q, vec_d;
   logic [3:0]   idx_q, idx_d;
   ITU_IRQ_t     served_q, served_d;

   ITU_IRQ_t     lines;
   ITU_IRQ_t     chan_en;
   ITU_IRQ_t     elig;
   logic         win_valid;
   logic [3:0]   win_idx;
   logic [3:0]   win_lvl;
   logic [7:0]   win_vec;

   always_comb begin
      lines   = '0;
      chan_en = '0;
      for (int n = 0; n < ITU_NCH; n++) begin
         lines[3*n]     = IMIA_IRQ[n];
         lines[3*n+1]   = IMIB_IRQ[n];
         lines[3*n+2]   = OVI_IRQ[n];
         chan_en[3*n]   = |IPR[4*n +: 4];
         chan_en[3*n+1] = |IPR[4*n +: 4];
         chan_en[3*n+2] = |IPR[4*n +: 4];
      end
   end

   assign elig = lines & chan_en & ~served_q;

   sh7034_itu_prio_enc u_prio_enc (
      .elig_i  (elig),
      .ipr_i   (IPR),
      .valid_o (win_valid),
      .idx_o   (win_idx),
      .lvl_o   (win_lvl)
   );

   assign win_vec = itu_vec(VEC_BASE, win_idx);

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      lvl_d    = lvl_q;
      vec_d    = vec_q;
      idx_d    = idx_q;
      served_d = served_q & lines;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               req_d   = 1'b1;
               lvl_d   = win_lvl;
               vec_d   = win_vec;
               idx_d   = win_idx;
               state_d = REQ;
            end
         end
         REQ: begin
            // The ack refers to what the CPU sampled, so it beats re-arbitration.
            if (INT_ACK) begin
               served_d[idx_q] = 1'b1;
               req_d           = 1'b0;
               state_d         = DONE;
            end else if (!win_valid) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end else begin
               lvl_d = win_lvl;
               vec_d = win_vec;
               idx_d = win_idx;
            end
         end
         DONE: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         lvl_q    <= 4'd0;
         vec_q    <= 8'd0;
         idx_q    <= 4'd0;
         served_q <= '0;
      end else if (CE_R) begin
         if (!RES_N) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            lvl_q    <= 4'd0;
            vec_q    <= 8'd0;
            idx_q    <= 4'd0;
            served_q <= '0;
         end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            lvl_q    <= lvl_d;
            vec_q    <= vec_d;
            idx_q    <= idx_d;
            served_q <= served_d;
         end
      end
   end

   assign INT_REQ   = req_q;
   assign INT_LVL   = lvl_q;
   assign INT_VEC   = vec_q;
   assign SERVED    = served_q;
   assign ARB_STATE = state_q;

endmodule

// File: tb/tb_sh7034_itu_irq_arb.sv
// Directed bench for sh7034_itu_irq_arb: a vector table walked one CE_R edge per row,
// then hand sequences for clock-enable hold, soft reset and asynchronous reset.
module tb_sh7034_itu_irq_arb;

   logic        clk;
   logic        rst;
   logic        ce_r;
   logic        res_n;
   logic [4:0]  imia_irq;
   logic [4:0]  imib_irq;
   logic [4:0]  ovi_irq;
   logic [19:0] ipr;
   logic        int_req;
   logic [3:0]  int_lvl;
   logic [7:0]  int_vec;
   logic        int_ack;
   logic [14:0] served;
   logic [1:0]  arb_state;

   int n_checks;
   int n_fail;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct {
      logic [4:0]  imia;
      logic [4:0]  imib;
      logic [4:0]  ovi;
      logic [19:0] ipr;
      logic        ack;
      logic        req;
      logic [3:0]  lvl;
      logic [7:0]  vec;
      logic [14:0] served;
      logic [1:0]  st;
   } vec_t;

   vec_t tbl[18];

   sh7034_itu_irq_arb #(.VEC_BASE(8'd24)) dut (
      .CLK       (clk),
      .RST       (rst),
      .CE_R      (ce_r),
      .RES_N     (res_n),
      .IMIA_IRQ  (imia_irq),
      .IMIB_IRQ  (imib_irq),
      .OVI_IRQ   (ovi_irq),
      .IPR       (ipr),
      .INT_REQ   (int_req),
      .INT_LVL   (int_lvl),
      .INT_VEC   (int_vec),
      .INT_ACK   (int_ack),
      .SERVED    (served),
      .ARB_STATE (arb_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic req, input logic [3:0] lvl,
                          input logic [7:0] vec, input logic [14:0] srv, input logic [1:0] st);
      chk({tag, " req"},    32'(int_req),   32'(req));
      chk({tag, " lvl"},    32'(int_lvl),   32'(lvl));
      chk({tag, " vec"},    32'(int_vec),   32'(vec));
      chk({tag, " served"}, 32'(served),    32'(srv));
      chk({tag, " state"},  32'(arb_state), 32'(st));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      ce_r     = 1'b1;
      res_n    = 1'b1;
      imia_irq = '0;
      imib_irq = '0;
      ovi_irq  = '0;
      ipr      = '0;
      int_ack  = 1'b0;

      // imia, imib, ovi, ipr, ack | req, lvl, vec, served, state
      tbl[0]  = '{5'b00001, 5'b00000, 5'b00000, 20'h00005, 1'b0, 1'b1, 4'd5,  8'd24, 15'h0000, ST_REQ};
      tbl[1]  = '{5'b00001, 5'b00000, 5'b00000, 20'h00005, 1'b1, 1'b0, 4'd5,  8'd24, 15'h0001, ST_DONE};
      tbl[2]  = '{5'b00001, 5'b00000, 5'b00000, 20'h00005, 1'b0, 1'b0, 4'd5,  8'd24, 15'h0001, ST_IDLE};
      tbl[3]  = '{5'b00001, 5'b00000, 5'b00000, 20'h00005, 1'b0, 1'b0, 4'd5,  8'd24, 15'h0001, ST_IDLE};
      tbl[4]  = '{5'b00000, 5'b00000, 5'b00000, 20'h00005, 1'b0, 1'b0, 4'd5,  8'd24, 15'h0000, ST_IDLE};
      tbl[5]  = '{5'b00000, 5'b01010, 5'b00000, 20'h09030, 1'b0, 1'b1, 4'd9,  8'd37, 15'h0000, ST_REQ};
      tbl[6]  = '{5'b00000, 5'b01010, 5'b00000, 20'h09030, 1'b1, 1'b0, 4'd9,  8'd37, 15'h0400, ST_DONE};
      tbl[7]  = '{5'b00000, 5'b00010, 5'b00000, 20'h09030, 1'b0, 1'b0, 4'd9,  8'd37, 15'h0000, ST_IDLE};
      tbl[8]  = '{5'b00000, 5'b00010, 5'b00000, 20'h09030, 1'b0, 1'b1, 4'd3,  8'd29, 15'h0000, ST_REQ};
      tbl[9]  = '{5'b00000, 5'b00000, 5'b00000, 20'h09030, 1'b0, 1'b0, 4'd3,  8'd29, 15'h0000, ST_IDLE};
      tbl[10] = '{5'b00000, 5'b00000, 5'b00000, 20'h09030, 1'b1, 1'b0, 4'd3,  8'd29, 15'h0000, ST_IDLE};
      tbl[11] = '{5'b00000, 5'b00000, 5'b10100, 20'h70700, 1'b0, 1'b1, 4'd7,  8'd34, 15'h0000, ST_REQ};
      tbl[12] = '{5'b00100, 5'b00000, 5'b10100, 20'h70700, 1'b0, 1'b1, 4'd7,  8'd32, 15'h0000, ST_REQ};
      tbl[13] = '{5'b00000, 5'b00000, 5'b00000, 20'h70700, 1'b0, 1'b0, 4'd7,  8'd32, 15'h0000, ST_IDLE};
      tbl[14] = '{5'b00001, 5'b00000, 5'b00000, 20'h00C02, 1'b0, 1'b1, 4'd2,  8'd24, 15'h0000, ST_REQ};
      tbl[15] = '{5'b00101, 5'b00000, 5'b00000, 20'h00C02, 1'b0, 1'b1, 4'd12, 8'd32, 15'h0000, ST_REQ};
      tbl[16] = '{5'b00101, 5'b00000, 5'b00000, 20'h00002, 1'b0, 1'b1, 4'd2,  8'd24, 15'h0000, ST_REQ};
      tbl[17] = '{5'b00101, 5'b00000, 5'b00000, 20'h00000, 1'b0, 1'b0, 4'd2,  8'd24, 15'h0000, ST_IDLE};

      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1'b0, 4'd0, 8'd0, 15'h0000, ST_IDLE);
      @(negedge clk);
      rst = 1'b0;

      // table walk, one CE_R edge per row
      for (int i = 0; i < 18; i++) begin
         imia_irq = tbl[i].imia;
         imib_irq = tbl[i].imib;
         ovi_irq  = tbl[i].ovi;
         ipr      = tbl[i].ipr;
         int_ack  = tbl[i].ack;
         step();
         chk_all($sformatf("row%0d", i), tbl[i].req, tbl[i].lvl, tbl[i].vec, tbl[i].served, tbl[i].st);
      end
      int_ack = 1'b0;

      // outputs hold while CE_R is low
      ipr      = 20'h00005;
      imia_irq = 5'b00001;
      ce_r     = 1'b0;
      step();
      step();
      chk_all("ce_hold_idle", 1'b0, 4'd2, 8'd24, 15'h0000, ST_IDLE);
      ce_r = 1'b1;
      step();
      chk_all("ce_req", 1'b1, 4'd5, 8'd24, 15'h0000, ST_REQ);
      ce_r    = 1'b0;
      int_ack = 1'b1;
      step();
      chk_all("ce_hold_ack", 1'b1, 4'd5, 8'd24, 15'h0000, ST_REQ);
      ce_r = 1'b1;
      step();
      chk_all("ack", 1'b0, 4'd5, 8'd24, 15'h0001, ST_DONE);
      int_ack = 1'b0;
      step();
      chk_all("post_done", 1'b0, 4'd5, 8'd24, 15'h0001, ST_IDLE);

      // soft reset clears the served mask, so the still-high line requests again
      res_n = 1'b0;
      step();
      chk_all("res_n", 1'b0, 4'd0, 8'd0, 15'h0000, ST_IDLE);
      res_n = 1'b1;
      step();
      chk_all("after_res_n", 1'b1, 4'd5, 8'd24, 15'h0000, ST_REQ);

      // asynchronous reset in the middle of REQ
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 1'b0, 4'd0, 8'd0, 15'h0000, ST_IDLE);
      step();
      chk_all("rst_held", 1'b0, 4'd0, 8'd0, 15'h0000, ST_IDLE);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk_all("after_rst", 1'b1, 4'd5, 8'd24, 15'h0000, ST_REQ);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
